// File: rtl/mem_write_collector_if.sv
// CPU store snoop port plus the captured-byte output stream of mem_write_collector.
// master drives stores and out_ready; slave is the collector.
interface mem_write_collector_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] out_offset;
    logic        out_last;

    modport master (
        output wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_data, out_offset, out_last
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_data, out_offset, out_last
    );
endinterface

// File: rtl/mem_write_collector.sv
// Snoops CPU stores into the output window / end-of-frame marker and queues them in a FWFT FIFO.
// Latency: store at edge N is the head in cycle N+1; backpressure: out_ready stalls, a full FIFO with no pop drops and sets overflow.
module mem_write_collector #(
    parameter logic [31:0] OUT_BASE  = 32'h0000_8000,
    parameter logic [31:0] OUT_SIZE  = 32'h0000_4000,
    parameter logic [31:0] DONE_ADDR = 32'h0000_FFFF,
    parameter int          DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_write_collector_if.slave     io_bus,
    input  logic                     i_clear_overflow,
    output logic                     o_frame_toggle,
    output logic [15:0]              o_frame_count,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // 33-bit window end so a window touching the top of the address space cannot wrap
    localparam logic [32:0] WIN_END = {1'b0, OUT_BASE} + {1'b0, OUT_SIZE};
    localparam logic [15:0] BASE_LO = OUT_BASE[15:0];

    typedef struct packed {
        logic        last;
        logic [15:0] offset;
        logic [7:0]  data;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic            r_frame_toggle;
    logic [15:0]     r_frame_count;

    logic            w_hit;
    logic            w_mark;
    logic            w_push_req;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    entry_t          w_entry;
    entry_t          w_head;

    assign w_hit      = io_bus.wr_en && (io_bus.wr_addr >= OUT_BASE)
                        && ({1'b0, io_bus.wr_addr} < WIN_END);
    assign w_mark     = io_bus.wr_en && (io_bus.wr_addr == DONE_ADDR);
    assign w_push_req = w_hit || w_mark;
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_pop      = (r_level != '0) && io_bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_comb begin
        w_entry = '0;
        if (w_mark) begin
            w_entry.last   = 1'b1;
            w_entry.offset = 16'hFFFF;
        end else begin
            w_entry.offset = io_bus.wr_addr[15:0] - BASE_LO;
        end
        w_entry.data = io_bus.wr_data;
    end

    // Storage is deliberately left out of reset; pointers and level define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_overflow     <= 1'b0;
            r_frame_toggle <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_mark) begin
                r_frame_toggle <= ~r_frame_toggle;
                r_frame_count  <= r_frame_count + 16'd1;
            end
        end
    end

    assign w_head            = r_mem[r_rd_ptr];
    assign io_bus.out_valid  = (r_level != '0);
    assign io_bus.out_data   = w_head.data;
    assign io_bus.out_offset = w_head.offset;
    assign io_bus.out_last   = w_head.last;

    assign o_level        = r_level;
    assign o_overflow     = r_overflow;
    assign o_frame_toggle = r_frame_toggle;
    assign o_frame_count  = r_frame_count;
endmodule

// File: tb/tb_mem_write_collector.sv
// Bench for mem_write_collector: queue-based reference model checked every cycle, plus literal expectations.
module tb_mem_write_collector;
    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam logic [31:0] SIZE  = 32'h0000_4000;
    localparam logic [31:0] DONE  = 32'h0000_FFFF;
    localparam int          DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        clear_overflow;
    logic        frame_toggle;
    logic [15:0] frame_count;
    logic [4:0]  level;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    mem_write_collector_if bus();

    mem_write_collector #(
        .OUT_BASE(BASE), .OUT_SIZE(SIZE), .DONE_ADDR(DONE), .DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .io_bus           (bus.slave),
        .i_clear_overflow (clear_overflow),
        .o_frame_toggle   (frame_toggle),
        .o_frame_count    (frame_count),
        .o_level          (level),
        .o_overflow       (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {last, offset, data} entries
    logic [24:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_tog = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        logic        in_win;
        logic        is_mark;
        logic [15:0] off;
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_tog = 1'b0;
            m_cnt = 16'd0;
        end else begin
            in_win  = bus.wr_en && (64'(bus.wr_addr) >= 64'(BASE))
                      && (64'(bus.wr_addr) < 64'(BASE) + 64'(SIZE));
            is_mark = bus.wr_en && (bus.wr_addr == DONE);
            off     = 16'(bus.wr_addr - BASE);
            if (clear_overflow) m_ovf = 1'b0;
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (in_win || is_mark) begin
                if (q.size() < DEPTH)
                    q.push_back(is_mark ? {1'b1, 16'hFFFF, bus.wr_data} : {1'b0, off, bus.wr_data});
                else
                    m_ovf = 1'b1;
            end
            if (is_mark) begin
                m_tog = ~m_tog;
                m_cnt = m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", bus.out_valid, q.size() != 0);
        chk("level", level, q.size());
        chk("overflow", overflow, m_ovf);
        chk("toggle", frame_toggle, m_tog);
        chk("count", frame_count, m_cnt);
        if (q.size() != 0) begin
            chk("head_last", bus.out_last, q[0][24]);
            chk("head_offset", bus.out_offset, q[0][23:8]);
            chk("head_data", bus.out_data, q[0][7:0]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b1;
        clear_overflow = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 32'h0;
        bus.wr_data    = 8'h0;
        bus.out_ready  = 1'b0;

        // Async reset with no clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_toggle", frame_toggle, 0);
        chk("rst_count", frame_count, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single capture
        store(32'h0000_8005, 8'hA5);
        chk("cap_valid", bus.out_valid, 1);
        chk("cap_data", bus.out_data, 8'hA5);
        chk("cap_offset", bus.out_offset, 16'h0005);
        chk("cap_last", bus.out_last, 0);
        chk("cap_level", level, 1);
        pop_one();
        chk("cap_pop_level", level, 0);

        // Window edges
        store(32'h0000_7FFF, 8'h01);
        store(32'h0000_C000, 8'h02);
        chk("edge_outside_level", level, 0);
        store(32'h0000_8000, 8'h03);
        store(32'h0000_BFFF, 8'h04);
        chk("edge_level", level, 2);
        chk("edge_first_off", bus.out_offset, 16'h0000);
        pop_one();
        chk("edge_second_off", bus.out_offset, 16'h3FFF);
        pop_one();
        pop_one();
        chk("edge_empty_ready", level, 0);

        // Markers
        store(32'h0000_FFFF, 8'h11);
        chk("mark_last", bus.out_last, 1);
        chk("mark_off", bus.out_offset, 16'hFFFF);
        chk("mark_data", bus.out_data, 8'h11);
        chk("mark_toggle1", frame_toggle, 1);
        chk("mark_count1", frame_count, 1);
        pop_one();
        store(32'h0000_FFFF, 8'h22);
        chk("mark_toggle2", frame_toggle, 0);
        chk("mark_count2", frame_count, 2);
        pop_one();

        // Overflow: 17 stores, last one dropped
        for (int i = 0; i < 17; i++) store(32'h0000_8000 + 32'(i), 8'(i));
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", bus.out_data, 8'h00);
        // Full FIFO, push and pop in the same cycle
        bus.out_ready = 1'b1;
        store(32'h0000_8010, 8'hEE);
        bus.out_ready = 1'b0;
        chk("fullpp_level", level, 16);
        chk("fullpp_head", bus.out_data, 8'h01);
        // Drop and clear in the same cycle: set wins
        clear_overflow = 1'b1;
        store(32'h0000_8011, 8'hDD);
        clear_overflow = 1'b0;
        chk("clr_vs_drop", overflow, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr_overflow", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", bus.out_data, (i < 15) ? 32'(i + 1) : 32'hEE);
            pop_one();
        end
        chk("drain_level", level, 0);

        // Async reset mid-stream
        for (int i = 0; i < 5; i++) store(32'h0000_8100 + 32'(i), 8'(8'h40 + i));
        chk("mid_level", level, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_level", level, 0);
        tick();
        rst_n = 1'b1;
        store(32'h0000_8001, 8'h5A);
        chk("post_rst_off", bus.out_offset, 16'h0001);
        chk("post_rst_data", bus.out_data, 8'h5A);
        chk("post_rst_level", level, 1);
        pop_one();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
